stall_flush_ctrl: RTL and testbench
===================================

# stall_flush_ctrl

Parametrised stall and flush controller for the in-order RISC-V pipeline, and successor to the fixed 5-bit id/mem stall controller. It merges any number of per-stage stall requests into a `stall` bus and adds three things the old block lacked: a multi-cycle hold timer, a flush output with deferral while the requesting stage is stalled, and a saturating stall-cycle counter. Stage 0 is the PC stage; a higher index is an older stage.

## Interface
Parameters:
- `STAGES`, default 5: pipeline stages, which is also the width of `stall` and `flush`.
- `NREQ`, default 2: number of stall-request sources.
- `IDXW`, default 3: stage-index width, at least $clog2(STAGES).
- `REQ_STAGE`, default {3'd3,3'd1}: flattened NREQ*IDXW vector. Source i uses `REQ_STAGE[i*IDXW +: IDXW]`; the default maps source 0 to id (1) and source 1 to mem (3).
- `LENW`, default 4: width of the hold length.
- `CNTW`, default 16: width of the stall counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high (`Enable`).
- `stall_req` in NREQ: per-source stall request, level, same-cycle.
- `hold_req` in 1: start a timed stall.
- `hold_stage` in IDXW: stage index for the hold.
- `hold_len` in LENW: hold duration in cycles.
- `flush_req` in 1: flush request, one-cycle pulse.
- `flush_stage` in IDXW: oldest stage to clear.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `stall` out STAGES: bit i=1 holds stage i.
- `flush` out STAGES: bit i=1 bubbles stage i this cycle.
- `hold_busy` out 1: the hold timer is running beyond its first cycle.
- `stall_cnt` out CNTW: count of cycles with any stall.

## Operation
- Define mask(k) as bits [k:0] set. Any k ≥ STAGES is clipped to STAGES-1.
- **Stall depth D** is the maximum of:
  - `REQ_STAGE[i]` over every asserted `stall_req[i]`;
  - `hold_stage_q` while the hold is active.
  - If there is no contributor, `stall` = 0. Otherwise `stall` = mask(D). This reproduces the legacy mapping: mem gives 01111 and id gives 00011.
- **Hold timer**:
  - A hold is accepted when `hold_req` = 1, the timer is idle (`hold_cnt` = 0), and `hold_len` ≠ 0.
  - The acceptance cycle is itself a hold cycle, using `hold_stage` directly.
  - On acceptance: `hold_stage_q` ← `hold_stage` and `hold_cnt` ← `hold_len`-1.
  - While `hold_cnt` ≠ 0, the hold is active and `hold_cnt` decrements each cycle.
  - Total hold duration is exactly `hold_len` cycles. `hold_busy` = (`hold_cnt` ≠ 0).
  - `hold_req` while busy, or with `hold_len` = 0, is ignored.
- **Flush**:
  - The candidate stage F is max(`pend_stage` if `pend_v`, `flush_stage` if `flush_req`).
  - Requester stage R = F+1.
  - A flush issues when a candidate exists and either R ≥ STAGES or the pre-flush `stall[R]` = 0. When it issues:
    - `flush` = mask(F);
    - `stall` bits [F:0] are forced to 0;
    - `pend_v` ← 0;
    - a hold with `hold_stage_q` ≤ F is cancelled (`hold_cnt` ← 0).
  - Otherwise the flush is deferred: `flush` = 0, `pend_v` ← 1, `pend_stage` ← F. Multiple deferred flushes merge to the maximum stage.
- **Stall counter**: `stall_cnt` increments on every cycle in which the final `stall[0]` = 1, saturating at all-ones. `cnt_clr` clears it and wins over the increment.

## Timing
- `stall` and `flush` are combinational from the inputs and registered state, with zero-cycle latency, so they must settle within the same cycle.
- The registered state is `hold_cnt`, `hold_stage_q`, `pend_v`, `pend_stage` and `stall_cnt`. All of it updates on the rising `clk` edge.
- A deferred flush issues in the first cycle in which `stall[R]` evaluates to 0. This may be the same cycle the blocking request drops.
- `flush` is asserted for exactly one cycle per issued flush.
- Behaviour during `rst`:
  - All registers are cleared asynchronously.
  - `stall` = 0, `flush` = 0, `hold_busy` = 0 and `stall_cnt` = 0 are forced, regardless of the inputs.
- Reset asserted mid-hold or with a flush pending discards that state, and no flush issues after release.
- A flush and a new `hold_req` in the same cycle: the flush is evaluated first. The hold is accepted only if its `hold_stage` > F; otherwise it is dropped.

## Test plan
Defaults unless stated: STAGES=5, NREQ=2, REQ_STAGE={3,1}.
- **Reset**: assert `rst` with all requests high → `stall`=00000, `flush`=00000, `stall_cnt`=0. Release → outputs follow the inputs the next cycle.
- **Legacy mapping**: `stall_req`=11 → `stall`=01111; `stall_req`=01 → 00011; `stall_req`=00 → 00000.
- **Hold timer**:
  - `hold_req`, stage 2, len 3 → `stall`=00111 for exactly 3 cycles, `hold_busy`=1 on cycles 2 and 3.
  - A second `hold_req` on cycle 2 is ignored.
  - len 0 → no stall.
- **Deferred flush**:
  - Pulse `flush_req` with stage 1 while `stall_req[1]`=1 → `flush`=00000 and `pend_v`=1.
  - Drop `stall_req` three cycles later → that cycle `flush`=00011, `stall`=00000, then `flush`=0.
- **Flush cancels hold**:
  - Set up a hold at stage 1, len 5. On its 2nd cycle pulse `flush_req` with stage 2 → `flush`=00111, `stall`=00000.
  - Next cycle: `hold_busy`=0.
- **Counter saturation**: with CNTW=4:
  - 20 stalled cycles → `stall_cnt`=15.
  - `cnt_clr` while stalled → 0 the next cycle.

Source files
------------

// File: rtl/stall_flush_ctrl.sv
// Stall/flush controller: merges per-stage stall requests, runs a timed hold,
// defers flushes while the requesting stage is stalled, counts stalled cycles.
module stall_flush_ctrl #(
  parameter int                   STAGES    = 5,
  parameter int                   NREQ      = 2,
  parameter int                   IDXW      = 3,
  parameter logic [NREQ*IDXW-1:0] REQ_STAGE = {3'd3, 3'd1},
  parameter int                   LENW      = 4,
  parameter int                   CNTW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              hold_req,
  input  logic [IDXW-1:0]   hold_stage,
  input  logic [LENW-1:0]   hold_len,
  input  logic              flush_req,
  input  logic [IDXW-1:0]   flush_stage,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              hold_busy,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam int RW = IDXW + 1;

  logic [LENW-1:0]   hold_cnt;
  logic [IDXW-1:0]   hold_stage_q;
  logic              pend_v;
  logic [IDXW-1:0]   pend_stage;

  logic              pre_v;
  logic [IDXW-1:0]   pre_d;
  logic [STAGES-1:0] pre_stall;
  logic              cand_v;
  logic [IDXW-1:0]   f_stage;
  logic [RW-1:0]     r_stage;
  logic              blocked;
  logic              issue;
  logic              cancel;
  logic              accept;
  logic              fin_v;
  logic [IDXW-1:0]   fin_d;
  logic [STAGES-1:0] fmask;

  // Indices at or beyond STAGES naturally saturate to all ones.
  function automatic logic [STAGES-1:0] mask_of(input logic [IDXW-1:0] k);
    logic [STAGES-1:0] m;
    for (int i = 0; i < STAGES; i++) m[i] = (int'(k) >= i);
    return m;
  endfunction

  assign hold_busy = (hold_cnt != '0);

  always_comb begin
    pre_v = 1'b0;
    pre_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stall_req[i] && (!pre_v || REQ_STAGE[i*IDXW +: IDXW] > pre_d)) begin
        pre_v = 1'b1;
        pre_d = REQ_STAGE[i*IDXW +: IDXW];
      end
    end
    if (hold_busy && (!pre_v || hold_stage_q > pre_d)) begin
      pre_v = 1'b1;
      pre_d = hold_stage_q;
    end
    pre_stall = pre_v ? mask_of(pre_d) : '0;

    // Flush candidate: oldest of the pending and the incoming request.
    cand_v  = pend_v | flush_req;
    f_stage = pend_v ? pend_stage : '0;
    if (flush_req && (!pend_v || flush_stage > f_stage)) f_stage = flush_stage;
    r_stage = {1'b0, f_stage} + RW'(1);

    blocked = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (int'(r_stage) == i) blocked = pre_stall[i];
    end
    issue  = cand_v && !blocked;
    cancel = issue && hold_busy && (hold_stage_q <= f_stage);
    fmask  = issue ? mask_of(f_stage) : '0;

    // A new hold competing with an issuing flush survives only above it.
    accept = hold_req && !hold_busy && (hold_len != '0) &&
             (!issue || hold_stage > f_stage);

    fin_v = pre_v;
    fin_d = pre_d;
    if (accept && (!fin_v || hold_stage > fin_d)) begin
      fin_v = 1'b1;
      fin_d = hold_stage;
    end

    stall = '0;
    flush = '0;
    if (!rst) begin
      stall = (fin_v ? mask_of(fin_d) : '0) & ~fmask;
      flush = fmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt     <= '0;
      hold_stage_q <= '0;
      pend_v       <= 1'b0;
      pend_stage   <= '0;
      stall_cnt    <= '0;
    end else begin
      if (accept) begin
        hold_cnt     <= hold_len - LENW'(1);
        hold_stage_q <= hold_stage;
      end else if (cancel) begin
        hold_cnt <= '0;
      end else if (hold_busy) begin
        hold_cnt <= hold_cnt - LENW'(1);
      end

      if (issue) begin
        pend_v <= 1'b0;
      end else if (cand_v) begin
        pend_v     <= 1'b1;
        pend_stage <= f_stage;
      end

      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (stall[0] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl with a queue-based scoreboard; the
// counter is built 4 bits wide so saturation is reachable.
module tb_stall_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] stall_req;
  logic       hold_req;
  logic [2:0] hold_stage;
  logic [3:0] hold_len;
  logic       flush_req;
  logic [2:0] flush_stage;
  logic       cnt_clr;
  logic [4:0] stall;
  logic [4:0] flush;
  logic       hold_busy;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int step_id = 0;

  typedef struct {
    int         id;
    logic [4:0] st;
    logic [4:0] fl;
    logic       bz;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  stall_flush_ctrl #(.STAGES(5), .NREQ(2), .IDXW(3), .REQ_STAGE({3'd3, 3'd1}),
                     .LENW(4), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .hold_req(hold_req),
    .hold_stage(hold_stage), .hold_len(hold_len), .flush_req(flush_req),
    .flush_stage(flush_stage), .cnt_clr(cnt_clr), .stall(stall), .flush(flush),
    .hold_busy(hold_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: outputs settle by the falling edge of each cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (stall !== e.st) begin
        errors++;
        $display("FAIL stall step %0d: got %b want %b", e.id, stall, e.st);
      end
      checks++;
      if (flush !== e.fl) begin
        errors++;
        $display("FAIL flush step %0d: got %b want %b", e.id, flush, e.fl);
      end
      checks++;
      if (hold_busy !== e.bz) begin
        errors++;
        $display("FAIL hold_busy step %0d: got %b want %b", e.id, hold_busy, e.bz);
      end
      if (e.cnt >= 0) begin
        checks++;
        if ($isunknown(stall_cnt) || int'(stall_cnt) != e.cnt) begin
          errors++;
          $display("FAIL stall_cnt step %0d: got %0d want %0d", e.id, stall_cnt, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input logic [4:0] es, input logic [4:0] ef, input logic eb, input int ec);
    exp_t e;
    step_id++;
    e.id = step_id; e.st = es; e.fl = ef; e.bz = eb; e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_req = 2'b00; hold_req = 1'b0; hold_stage = 3'd0; hold_len = 4'd0;
    flush_req = 1'b0; flush_stage = 3'd0; cnt_clr = 1'b0;
  endtask

  initial begin
    // Reset with every request asserted.
    rst = 1'b1;
    stall_req = 2'b11; hold_req = 1'b1; hold_stage = 3'd2; hold_len = 4'd3;
    flush_req = 1'b1; flush_stage = 3'd1; cnt_clr = 1'b0;
    @(posedge clk); #1;
    cyc(5'b00000, 5'b00000, 1'b0, 0);
    cyc(5'b00000, 5'b00000, 1'b0, 0);

    rst = 1'b0; idle_inputs();
    // Legacy mapping
    stall_req = 2'b11; cyc(5'b01111, 5'b00000, 1'b0, 0);
    stall_req = 2'b01; cyc(5'b00011, 5'b00000, 1'b0, 1);
    stall_req = 2'b00; cyc(5'b00000, 5'b00000, 1'b0, 2);
    stall_req = 2'b10; cyc(5'b01111, 5'b00000, 1'b0, 2);
    stall_req = 2'b00; cyc(5'b00000, 5'b00000, 1'b0, 3);

    // Hold stage 2 len 3, second request ignored, then len 0
    hold_req = 1'b1; hold_stage = 3'd2; hold_len = 4'd3;
    cyc(5'b00111, 5'b00000, 1'b0, 3);
    hold_stage = 3'd4; hold_len = 4'd2;
    cyc(5'b00111, 5'b00000, 1'b1, 4);
    hold_req = 1'b0;
    cyc(5'b00111, 5'b00000, 1'b1, 5);
    cyc(5'b00000, 5'b00000, 1'b0, 6);
    hold_req = 1'b1; hold_stage = 3'd3; hold_len = 4'd0;
    cyc(5'b00000, 5'b00000, 1'b0, 6);
    hold_req = 1'b0;
    cyc(5'b00000, 5'b00000, 1'b0, 6);

    // Deferred flush behind a mem stall
    stall_req = 2'b10; flush_req = 1'b1; flush_stage = 3'd1;
    cyc(5'b01111, 5'b00000, 1'b0, 6);
    flush_req = 1'b0;
    cyc(5'b01111, 5'b00000, 1'b0, 7);
    cyc(5'b01111, 5'b00000, 1'b0, 8);
    stall_req = 2'b00;
    cyc(5'b00000, 5'b00011, 1'b0, 9);
    cyc(5'b00000, 5'b00000, 1'b0, 9);

    // Flush cancels hold
    hold_req = 1'b1; hold_stage = 3'd1; hold_len = 4'd5;
    cyc(5'b00011, 5'b00000, 1'b0, 9);
    hold_req = 1'b0; flush_req = 1'b1; flush_stage = 3'd2;
    cyc(5'b00000, 5'b00111, 1'b1, 10);
    flush_req = 1'b0;
    cyc(5'b00000, 5'b00000, 1'b0, 10);

    // Same-cycle flush and hold: dropped at/below F, kept above F
    flush_req = 1'b1; flush_stage = 3'd2; hold_req = 1'b1; hold_stage = 3'd1; hold_len = 4'd3;
    cyc(5'b00000, 5'b00111, 1'b0, 10);
    idle_inputs();
    cyc(5'b00000, 5'b00000, 1'b0, 10);
    flush_req = 1'b1; flush_stage = 3'd0; hold_req = 1'b1; hold_stage = 3'd3; hold_len = 4'd2;
    cyc(5'b01110, 5'b00001, 1'b0, 10);
    idle_inputs();
    cyc(5'b01111, 5'b00000, 1'b1, 10);
    cyc(5'b00000, 5'b00000, 1'b0, 11);

    // Flush index beyond the pipeline issues at once, clipped
    stall_req = 2'b11; flush_req = 1'b1; flush_stage = 3'd7;
    cyc(5'b00000, 5'b11111, 1'b0, 11);
    flush_req = 1'b0;
    cyc(5'b01111, 5'b00000, 1'b0, 11);

    // Two deferred flushes merge to the older stage
    stall_req = 2'b10; flush_req = 1'b1; flush_stage = 3'd0;
    cyc(5'b01111, 5'b00000, 1'b0, 12);
    flush_stage = 3'd1;
    cyc(5'b01111, 5'b00000, 1'b0, 13);
    flush_req = 1'b0; stall_req = 2'b00;
    cyc(5'b00000, 5'b00011, 1'b0, 14);
    cyc(5'b00000, 5'b00000, 1'b0, 14);

    // Reset with a flush pending discards it
    stall_req = 2'b10; flush_req = 1'b1; flush_stage = 3'd1;
    cyc(5'b01111, 5'b00000, 1'b0, 14);
    flush_req = 1'b0; rst = 1'b1;
    cyc(5'b00000, 5'b00000, 1'b0, 0);
    rst = 1'b0; stall_req = 2'b00;
    cyc(5'b00000, 5'b00000, 1'b0, 0);

    // Counter saturation and clear
    stall_req = 2'b01;
    for (int k = 0; k < 20; k++) cyc(5'b00011, 5'b00000, 1'b0, (k < 15) ? k : 15);
    cnt_clr = 1'b1;
    cyc(5'b00011, 5'b00000, 1'b0, 15);
    cnt_clr = 1'b0;
    cyc(5'b00011, 5'b00000, 1'b0, 0);
    cyc(5'b00011, 5'b00000, 1'b0, 1);
    idle_inputs();

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
